// File: rtl/brcomp_seq.sv
// Multi-cycle RISC-V branch comparator: scans rs1/rs2 one slice per cycle, MSB slice first,
// and resolves BrEq/BrLt/taken behind valid/ready handshakes on both sides.
module brcomp_seq #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned CHUNK_W    = 8,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] rs1_i,
   input  logic [WIDTH-1:0] rs2_i,
   input  logic [2:0]       funct3_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             BrEq_o,
   output logic             BrLt_o,
   output logic             taken_o,
   output logic             illegal_o
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

   if ((WIDTH % CHUNK_W) != 0) begin : g_bad_width
      $error("brcomp_seq: WIDTH must be a multiple of CHUNK_W");
   end

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2:0]         f3_q, f3_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               eq_acc_q, eq_acc_d, lt_acc_q, lt_acc_d;
   logic               ready_q, ready_d, valid_q, valid_d;
   logic               br_eq_q, br_eq_d, br_lt_q, br_lt_d;
   logic               taken_q, taken_d, illegal_q, illegal_d;

   logic [CHUNK_W-1:0] sa, sb;
   logic               diff, eq_nxt, lt_nxt, last;

   // Current slice and the accumulators after folding it in
   assign sa     = a_q[32'(idx_q) * CHUNK_W +: CHUNK_W];
   assign sb     = b_q[32'(idx_q) * CHUNK_W +: CHUNK_W];
   assign diff   = (sa != sb);
   assign eq_nxt = eq_acc_q & ~diff;
   assign lt_nxt = (eq_acc_q && diff) ? (sa < sb) : lt_acc_q;
   assign last   = (idx_q == '0) || (EARLY_EXIT && diff);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      f3_d      = f3_q;
      idx_d     = idx_q;
      eq_acc_d  = eq_acc_q;
      lt_acc_d  = lt_acc_q;
      valid_d   = valid_q;
      br_eq_d   = br_eq_q;
      br_lt_d   = br_lt_q;
      taken_d   = taken_q;
      illegal_d = illegal_q;
      ready_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_i && ready_q) begin
               // Signed compare becomes unsigned once the sign bits are flipped
               a_d      = funct3_i[1] ? rs1_i : (rs1_i ^ SIGN_MASK);
               b_d      = funct3_i[1] ? rs2_i : (rs2_i ^ SIGN_MASK);
               f3_d     = funct3_i;
               idx_d    = IDX_W'(NCHUNK - 1);
               eq_acc_d = 1'b1;
               lt_acc_d = 1'b0;
               state_d  = CMP;
            end
         end
         CMP: begin
            eq_acc_d = eq_nxt;
            lt_acc_d = lt_nxt;
            if (last) begin
               br_eq_d   = eq_nxt;
               br_lt_d   = lt_nxt;
               illegal_d = 1'b0;
               case (f3_q)
                  3'b000:         taken_d = eq_nxt;
                  3'b001:         taken_d = ~eq_nxt;
                  3'b100, 3'b110: taken_d = lt_nxt;
                  3'b101, 3'b111: taken_d = ~lt_nxt;
                  default: begin
                     taken_d   = 1'b0;
                     illegal_d = 1'b1;
                  end
               endcase
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         DONE: begin
            if (ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         f3_q      <= '0;
         idx_q     <= '0;
         eq_acc_q  <= 1'b0;
         lt_acc_q  <= 1'b0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         br_eq_q   <= 1'b0;
         br_lt_q   <= 1'b0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         f3_q      <= f3_d;
         idx_q     <= idx_d;
         eq_acc_q  <= eq_acc_d;
         lt_acc_q  <= lt_acc_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         br_eq_q   <= br_eq_d;
         br_lt_q   <= br_lt_d;
         taken_q   <= taken_d;
         illegal_q <= illegal_d;
      end
   end

   assign ready_o   = ready_q;
   assign valid_o   = valid_q;
   assign BrEq_o    = br_eq_q;
   assign BrLt_o    = br_lt_q;
   assign taken_o   = taken_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_brcomp_seq.sv
// Directed + random bench for brcomp_seq; an early-exit and a full-scan instance share stimulus.
module tb_brcomp_seq;

   logic        clk = 1'b0;
   logic        rst_i, valid_i, ready_i;
   logic [31:0] rs1, rs2;
   logic [2:0]  funct3;
   logic        ready_e, valid_e, eq_e, lt_e, taken_e, ill_e;
   logic        ready_z, valid_z, eq_z, lt_z, taken_z, ill_z;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   brcomp_seq #(.WIDTH(32), .CHUNK_W(8), .EARLY_EXIT(1'b1)) dut_e (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_e),
      .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3), .valid_o(valid_e), .ready_i(ready_i),
      .BrEq_o(eq_e), .BrLt_o(lt_e), .taken_o(taken_e), .illegal_o(ill_e));

   brcomp_seq #(.WIDTH(32), .CHUNK_W(8), .EARLY_EXIT(1'b0)) dut_z (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_z),
      .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3), .valid_o(valid_z), .ready_i(ready_i),
      .BrEq_o(eq_z), .BrLt_o(lt_z), .taken_o(taken_z), .illegal_o(ill_z));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat_early(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] d;
      d = x ^ y;
      for (int j = 3; j >= 0; j--)
         if (d[j*8 +: 8] != 8'h00) return 4 - j;
      return 4;
   endfunction

   // Issue one request, count edges to valid_o on both instances, check results; DONE held afterwards
   task automatic req(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [2:0] f);
      logic eq, lt, tk, il;
      int   l_e, l_z;
      eq = (x == y);
      lt = f[1] ? (x < y) : ($signed(x) < $signed(y));
      il = (f == 3'b010) || (f == 3'b011);
      case (f)
         3'b000:         tk = eq;
         3'b001:         tk = !eq;
         3'b100, 3'b110: tk = lt;
         3'b101, 3'b111: tk = !lt;
         default:        tk = 1'b0;
      endcase
      chk({tag, "_ready_in"}, {ready_e, ready_z}, 2'b11);
      rs1 = x; rs2 = y; funct3 = f; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      chk({tag, "_ready_busy"}, {ready_e, ready_z}, 2'b00);
      l_e = 0; l_z = 0;
      for (int n = 1; n <= 20 && (l_e == 0 || l_z == 0); n++) begin
         step();
         if (valid_e && l_e == 0) l_e = n;
         if (valid_z && l_z == 0) l_z = n;
      end
      chk({tag, "_lat_early"}, l_e, exp_lat_early(x, y));
      chk({tag, "_lat_full"},  l_z, 4);
      chk({tag, "_eq"},    {eq_e, eq_z},       {eq, eq});
      chk({tag, "_lt"},    {lt_e, lt_z},       {lt, lt});
      chk({tag, "_taken"}, {taken_e, taken_z}, {tk, tk});
      chk({tag, "_ill"},   {ill_e, ill_z},     {il, il});
   endtask

   task automatic release_done(input string tag);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      chk({tag, "_valid_drop"}, {valid_e, valid_z}, 2'b00);
      chk({tag, "_ready_back"}, {ready_e, ready_z}, 2'b11);
   endtask

   initial begin
      logic [31:0] x, y;
      logic [2:0]  f;
      logic [2:0]  legal [6];
      legal = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
      rs1 = '0; rs2 = '0; funct3 = '0;
      step();
      step();
      chk("reset_state", {ready_e, valid_e, eq_e, lt_e, taken_e, ill_e,
                          ready_z, valid_z, eq_z, lt_z, taken_z, ill_z}, 12'h000);
      rst_i = 1'b0;
      step();
      chk("reset_ready", {ready_e, ready_z}, 2'b11);

      // Reset in the middle of a compare aborts it
      rs1 = 32'hAABB_CCDD; rs2 = 32'hAABB_CCDD; funct3 = 3'b000; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      step();
      step();
      rst_i = 1'b1;
      step();
      chk("abort_in_reset", {valid_e, valid_z, ready_e, ready_z}, 4'b0000);
      rst_i = 1'b0;
      step();
      chk("abort_ready", {ready_e, ready_z}, 2'b11);
      for (int n = 0; n < 5; n++) begin
         step();
         chk("abort_no_valid", {valid_e, valid_z}, 2'b00);
      end

      // Signed vs unsigned with -1 and 1
      req("blt_m1", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
      chk("blt_m1_const", {eq_e, lt_e, taken_e}, 3'b011);
      release_done("blt_m1");
      req("bltu_m1", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
      chk("bltu_m1_const", {eq_e, lt_e, taken_e}, 3'b000);
      release_done("bltu_m1");

      // Early exit on top slice, full scan on equal operands
      req("early", 32'h1200_0000, 32'h1300_0000, 3'b000);
      chk("early_const", {eq_e, lt_e, taken_e}, 3'b010);
      release_done("early");
      req("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000);
      chk("equal_const", {eq_e, taken_e}, 2'b11);
      release_done("equal");

      // Full scan still reports signed ordering
      req("bge_min", 32'h8000_0000, 32'h0000_0000, 3'b101);
      chk("bge_min_const", {lt_z, taken_z}, 2'b10);
      release_done("bge_min");

      // Backpressure: DONE holds and ignores a new request
      req("bp", 32'h0000_0010, 32'h0000_0020, 3'b001);
      rs1 = 32'h5; rs2 = 32'h5; funct3 = 3'b000; valid_i = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         chk("bp_hold", {valid_e, valid_z, ready_e, ready_z}, 4'b1100);
         chk("bp_outs", {eq_e, lt_e, taken_e, ill_e, eq_z, lt_z, taken_z, ill_z}, 8'b0110_0110);
      end
      valid_i = 1'b0;
      release_done("bp");
      req("bp_next", 32'h0000_0005, 32'h0000_0005, 3'b000);
      chk("bp_next_const", {eq_e, taken_e}, 2'b11);
      release_done("bp_next");

      // Reserved funct3 still compares
      req("illegal", 32'h5, 32'h5, 3'b010);
      chk("illegal_const", {ill_e, taken_e, eq_e}, 3'b101);
      release_done("illegal");

      // Random vectors, some sharing upper slices to vary early-exit depth
      for (int i = 0; i < 200; i++) begin
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 4))
            0: y = x;
            1: y = {x[31:8], y[7:0]};
            2: y = {x[31:16], y[15:0]};
            3: y = {x[31:24], y[23:0]};
            default: ;
         endcase
         f = legal[$urandom_range(0, 5)];
         req("rand", x, y, f);
         release_done("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
